cia_timer_bank: RTL

//  Parametrised bank of CIA-style interval timers for drive/peripheral cores. It generalises the
//  8520/6526 A/B timer pair to NUM_TIMERS channels of TIMER_W bits with per-channel cascading and
//  one-shot/continuous modes. It adds coherent multi-byte reads and a shared ICR/IMR interrupt unit.
//  It sits on the 8-bit CPU bus beside a CIA or VIA and uses the same phi2 enables.

---
 rtl/cia_timer_bank_if.sv | 21 ++
 rtl/cia_timer_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cia_timer_bank_if.sv
// CPU-side bus of the timer bank: phi2 strobes, chip select, direction,
// register select and the two 8-bit data paths.
interface cia_timer_bank_if;
  logic       phi2_p;
  logic       phi2_n;
  logic       cs_n;
  logic       rw;
  logic [5:0] rs;
  logic [7:0] db_in;
  logic [7:0] db_out;

  modport master (
    output phi2_p, phi2_n, cs_n, rw, rs, db_in,
    input  db_out
  );

  modport slave (
    input  phi2_p, phi2_n, cs_n, rw, rs, db_in,
    output db_out
  );
endinterface

// File: rtl/cia_timer_bank.sv
// Bank of CIA-style interval timers with cascading, one-shot/continuous modes,
// coherent multi-byte counter reads and a shared ICR/IMR interrupt unit.
module cia_timer_bank #(
  parameter int NUM_TIMERS = 4,
  parameter int TIMER_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  cia_timer_bank_if.slave       bus,
  input  logic                  cnt_in,
  output logic [NUM_TIMERS-1:0] tmr_out,
  output logic                  irq_n
);
  localparam int NB = TIMER_W / 8;

  localparam logic [1:0] SRC_PHI2     = 2'd0;
  localparam logic [1:0] SRC_CNT      = 2'd1;
  localparam logic [1:0] SRC_CASC     = 2'd2;

  logic [TIMER_W-1:0]    latch_q [NUM_TIMERS];
  logic [TIMER_W-1:0]    count_q [NUM_TIMERS];
  logic [TIMER_W-1:0]    snap_q  [NUM_TIMERS];
  logic [1:0]            src_q   [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] start_q, out_en_q, toggle_q, oneshot_q, force_q;
  logic [NUM_TIMERS-1:0] ff_q, pulse_q, snap_valid_q;
  logic [NUM_TIMERS-1:0] icr_q, imr_q;
  logic [NUM_TIMERS-1:0] tick, uf;
  logic                  icr_clr_q, cnt_q, cnt_pend_q, cnt_edge;
  logic                  rd, wr;
  logic [2:0]            sel_ch, sel_k;
  logic [7:0]            rd_data;

  assign rd       = bus.phi2_n & ~bus.cs_n & bus.rw;
  assign wr       = bus.phi2_n & ~bus.cs_n & ~bus.rw;
  assign sel_ch   = bus.rs[5:3];
  assign sel_k    = bus.rs[2:0];
  // A CNT rising edge seen on any clk is remembered until the next phi2_p.
  assign cnt_edge = cnt_pend_q | (cnt_in & ~cnt_q);

  // Replace byte k of a latch image with new write data.
  function automatic logic [TIMER_W-1:0] merge_byte(input logic [TIMER_W-1:0] old,
                                                    input logic [2:0] k,
                                                    input logic [7:0] d);
    logic [TIMER_W-1:0] mask;
    mask = TIMER_W'(8'hFF) << {k, 3'b000};
    return (old & ~mask) | (TIMER_W'(d) << {k, 3'b000});
  endfunction

  // Tick/underflow ripple: channel i sees channel i-1's underflow on the same phi2_p.
  always_comb begin
    logic prev_uf, src_hit, t;
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    prev_uf = 1'b0;
    src_hit = 1'b0;
    t       = 1'b0;
    tick    = '0;
    uf      = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      case (src_q[i])
        SRC_PHI2: src_hit = 1'b1;
        SRC_CNT:  src_hit = cnt_edge;
        SRC_CASC: src_hit = prev_uf;
        default:  src_hit = prev_uf & cnt_in;
      endcase
      t       = bus.phi2_p & start_q[i] & src_hit;
      tick[i] = t;
      uf[i]   = t & (count_q[i] == '0);
      prev_uf = t & (count_q[i] == '0);
    end
  end

  // Read data mux: counter bytes (snapshot for upper bytes), CTRL, ICR.
  always_comb begin
    logic [TIMER_W-1:0] sh;
    rd_data = '0;
    sh      = '0;
    if (sel_ch == 3'd7) begin
      if (sel_k == 3'd0) rd_data = {~irq_n, 7'(icr_q)};
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (sel_ch == 3'(i)) begin
          if (int'(sel_k) < NB) begin
            sh      = (sel_k != 3'd0 && snap_valid_q[i]) ? snap_q[i] : count_q[i];
            sh      = sh >> {sel_k, 3'b000};
            rd_data = sh[7:0];
          end else if (sel_k == 3'd4) begin
            rd_data = {1'b0, src_q[i], 1'b0, oneshot_q[i], toggle_q[i], out_en_q[i], start_q[i]};
          end
        end
      end
    end
  end

  // Per-channel output pin: idle high, toggle flip-flop, or one-phi2 underflow pulse.
  always_comb begin
    tmr_out = '1;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (out_en_q[i]) tmr_out[i] = toggle_q[i] ? ff_q[i] : pulse_q[i];
    end
  end

  // Counters, control registers, bus writes/reads and interrupt state.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-channel arrays are a handful of flops, not RAM, so they are reset
      // explicitly to give software a defined latch/counter image after reset.
      for (int i = 0; i < NUM_TIMERS; i++) begin
        latch_q[i] <= '1;
        count_q[i] <= '0;
        snap_q[i]  <= '0;
        src_q[i]   <= '0;
      end
      start_q      <= '0;
      out_en_q     <= '0;
      toggle_q     <= '0;
      oneshot_q    <= '0;
      force_q      <= '0;
      ff_q         <= '0;
      pulse_q      <= '0;
      snap_valid_q <= '0;
      icr_q        <= '0;
      imr_q        <= '0;
      icr_clr_q    <= 1'b0;
      cnt_q        <= 1'b0;
      cnt_pend_q   <= 1'b0;
      irq_n        <= 1'b1;
      bus.db_out   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; later statements in this block
      // deliberately override earlier ones for the same clock (bus beats count).
      cnt_q      <= cnt_in;
      cnt_pend_q <= bus.phi2_p ? 1'b0 : cnt_edge;

      if (bus.phi2_p && icr_clr_q) irq_n <= 1'b1;
      else                         irq_n <= ~|(icr_q & imr_q);

      if (bus.phi2_p) begin
        icr_clr_q <= 1'b0;
        icr_q     <= icr_clr_q ? uf : (icr_q | uf);
        for (int i = 0; i < NUM_TIMERS; i++) begin
          pulse_q[i] <= uf[i];
          if (force_q[i]) begin
            count_q[i] <= latch_q[i];
            force_q[i] <= 1'b0;
          end else if (uf[i]) begin
            count_q[i] <= latch_q[i];
          end else if (tick[i]) begin
            count_q[i] <= count_q[i] - 1'b1;
          end
          if (uf[i]) begin
            ff_q[i] <= ~ff_q[i];
            if (oneshot_q[i]) start_q[i] <= 1'b0;
          end
        end
      end

      if (rd) begin
        bus.db_out <= rd_data;
        if (sel_ch == 3'd7 && sel_k == 3'd0) icr_clr_q <= 1'b1;
        for (int i = 0; i < NUM_TIMERS; i++) begin
          if (sel_ch == 3'(i) && sel_k == 3'd0) begin
            snap_q[i]       <= count_q[i];
            snap_valid_q[i] <= 1'b1;
          end
        end
      end

      if (wr) begin
        if (sel_ch == 3'd7 && sel_k == 3'd0) begin
          if (bus.db_in[7]) imr_q <= imr_q | bus.db_in[NUM_TIMERS-1:0];
          else              imr_q <= imr_q & ~bus.db_in[NUM_TIMERS-1:0];
        end
        for (int i = 0; i < NUM_TIMERS; i++) begin
          if (sel_ch == 3'(i)) begin
            snap_valid_q[i] <= 1'b0;
            if (int'(sel_k) < NB) begin
              latch_q[i] <= merge_byte(latch_q[i], sel_k, bus.db_in);
              // Top byte completes the latch: a stopped or one-shot timer loads at once.
              if (sel_k == 3'(NB-1) && (!start_q[i] || oneshot_q[i])) begin
                count_q[i] <= merge_byte(latch_q[i], sel_k, bus.db_in);
                if (oneshot_q[i]) start_q[i] <= 1'b1;
              end
            end else if (sel_k == 3'd4) begin
              start_q[i]   <= bus.db_in[0];
              out_en_q[i]  <= bus.db_in[1];
              toggle_q[i]  <= bus.db_in[2];
              oneshot_q[i] <= bus.db_in[3];
              force_q[i]   <= bus.db_in[4];
              src_q[i]     <= bus.db_in[6:5];
              if (bus.db_in[0] && !start_q[i]) ff_q[i] <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule
